// File: rtl/key_beep_pkg.sv
// rtl/key_beep_pkg.sv - shared types and default timing for the key beep controller
package key_beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef logic [1:0] ev_t;

  localparam ev_t EV_NONE  = 2'd0;
  localparam ev_t EV_SHORT = 2'd1;
  localparam ev_t EV_LONG  = 2'd2;

  // Defaults assume a 50 MHz system clock
  localparam int DEF_LONG_CNT    = 50_000_000;
  localparam int DEF_BEEP_ON     = 5_000_000;
  localparam int DEF_BEEP_GAP    = 5_000_000;
  localparam int DEF_TONE_HALF   = 12_500;
  localparam int DEF_LONG_BURSTS = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// rtl/beep_tone_gen.sv - square-wave tone source, phase cleared whenever disabled
module beep_tone_gen
  import key_beep_pkg::*;
#(
  parameter int TONE_HALF = DEF_TONE_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tone
);

  localparam int TW = $clog2(TONE_HALF);
  localparam logic [TW-1:0] HALF_LAST = TW'(TONE_HALF - 1);

  logic [TW-1:0] tone_cnt;

  // Half-period counter; toggling at wrap gives a 50% duty tone starting low
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (tone_cnt == HALF_LAST) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_beep_ctrl.sv
// rtl/key_beep_ctrl.sv - key press classifier and buzzer burst sequencer
module key_beep_ctrl
  import key_beep_pkg::*;
#(
  parameter int LONG_CNT    = DEF_LONG_CNT,
  parameter int BEEP_ON     = DEF_BEEP_ON,
  parameter int BEEP_GAP    = DEF_BEEP_GAP,
  parameter int TONE_HALF   = DEF_TONE_HALF,
  parameter int LONG_BURSTS = DEF_LONG_BURSTS
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  input  logic mute,
  output logic beep,
  output logic beep_busy,
  output logic short_pulse,
  output logic long_pulse,
  output logic key_held
);

  generate
    if (LONG_CNT < 2 || BEEP_ON < 2 || BEEP_GAP < 2 || TONE_HALF < 2 ||
        LONG_BURSTS < 1 || LONG_BURSTS > 7) begin : g_bad_param
      $error("key_beep_ctrl: timing parameters must be >= 2 and LONG_BURSTS in 1..7");
    end
  endgenerate

  localparam int HW = $clog2(LONG_CNT + 1);
  localparam int PW = $clog2(max2(BEEP_ON, BEEP_GAP) + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);
  localparam logic [PW-1:0] ON_LAST  = PW'(BEEP_ON - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(BEEP_GAP - 1);
  localparam logic [2:0]    LONG_N   = 3'(LONG_BURSTS);

  logic          key_q;
  logic          armed;
  logic          long_done;
  logic [HW-1:0] hold_cnt;
  logic          held_now, press_det, release_det, long_det, short_det;
  ev_t           ev;

  state_t        state;
  logic [PW-1:0] phase_cnt;
  logic [2:0]    bursts_left;
  logic          tone, tone_en;

  // armed stays low after reset until the key is seen up, so a key held
  // through reset never registers as a fresh press
  assign held_now    = armed & ~key_q & ~key_in;
  assign press_det   = armed &  key_q & ~key_in;
  assign release_det = armed & ~key_q &  key_in;
  assign long_det    = held_now & ~long_done & (hold_cnt == HOLD_MAX - 1'b1);
  assign short_det   = release_det & ~long_done;
  assign key_held    = ~key_q;

  // One event per press; the two detectors are mutually exclusive anyway
  always_comb begin
    ev = EV_NONE;
    if (long_det)       ev = EV_LONG;
    else if (short_det) ev = EV_SHORT;
  end

  // Key edge tracking, hold counting and event pulse generation
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_q       <= 1'b1;
      armed       <= 1'b0;
      long_done   <= 1'b0;
      hold_cnt    <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      key_q       <= key_in;
      armed       <= armed | key_in;
      short_pulse <= short_det;
      long_pulse  <= long_det;
      if (press_det || release_det)
        hold_cnt <= '0;
      else if (held_now && hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
      if (release_det)
        long_done <= 1'b0;
      else if (long_det)
        long_done <= 1'b1;
    end
  end

  // Burst sequencer; any new event restarts from a fresh ON phase
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      bursts_left <= '0;
      beep_busy   <= 1'b0;
    end else if (ev != EV_NONE) begin
      state       <= ON;
      phase_cnt   <= '0;
      bursts_left <= (ev == EV_LONG) ? LONG_N : 3'd1;
      beep_busy   <= 1'b1;
    end else begin
      case (state)
        ON: begin
          if (phase_cnt == ON_LAST) begin
            phase_cnt   <= '0;
            bursts_left <= bursts_left - 3'd1;
            if (bursts_left == 3'd1) begin
              state     <= IDLE;
              beep_busy <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        GAP: begin
          if (phase_cnt == GAP_LAST) begin
            phase_cnt <= '0;
            state     <= ON;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          beep_busy <= 1'b0;
        end
      endcase
    end
  end

  // Dropping enable for one edge on restart realigns the tone phase
  assign tone_en = (state == ON) && (ev == EV_NONE);

  beep_tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .enable(tone_en),
    .tone  (tone)
  );

  // Buzzer drive, masked outside ON so a final wrap never leaks into a gap
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      beep <= 1'b0;
    else
      beep <= tone & (state == ON) & ~mute;
  end

endmodule

// File: tb/tb_key_beep_ctrl.sv
// tb/tb_key_beep_ctrl.sv - directed self-checking bench for key_beep_ctrl
module tb_key_beep_ctrl;

  logic clk = 1'b0;
  logic sys_rst_n, key_in, mute;
  logic beep, beep_busy, short_pulse, long_pulse, key_held;

  int n_tests = 0;
  int n_fail  = 0;

  int n_short = 0, n_long = 0, n_busy = 0, n_hi = 0, n_rise = 0, n_both = 0;
  logic beep_d = 1'b0;
  int s_short, s_long, s_busy, s_hi, s_rise;

  key_beep_ctrl #(
    .LONG_CNT(100), .BEEP_ON(20), .BEEP_GAP(10), .TONE_HALF(4), .LONG_BURSTS(3)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .mute       (mute),
    .beep       (beep),
    .beep_busy  (beep_busy),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  // Running activity counters sampled mid-cycle
  always @(negedge clk) begin
    if (short_pulse) n_short++;
    if (long_pulse) n_long++;
    if (short_pulse && long_pulse) n_both++;
    if (beep_busy) n_busy++;
    if (beep) n_hi++;
    if (beep && !beep_d) n_rise++;
    beep_d = beep;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s_short = n_short;
    s_long  = n_long;
    s_busy  = n_busy;
    s_hi    = n_hi;
    s_rise  = n_rise;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 500 && beep_busy; i++) step(1);
    check(tag, beep_busy, 0);
    step(3);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    mute      = 1'b0;
    step(3);
    check("rst_beep", beep, 0);
    check("rst_busy", beep_busy, 0);
    check("rst_short", short_pulse, 0);
    check("rst_long", long_pulse, 0);
    check("rst_held", key_held, 0);
    sys_rst_n = 1'b1;
    step(2);

    // 1: 30-clock press -> short, one burst
    snap();
    key_in = 1'b0;
    check("t1_held_before", key_held, 0);
    step(1);
    check("t1_held_after", key_held, 1);
    step(29);
    key_in = 1'b1;
    step(1);
    check("t1_short_pulse", short_pulse, 1);
    check("t1_busy_start", beep_busy, 1);
    step(4);
    check("t1_beep_p4", beep, 0);
    step(1);
    check("t1_beep_p5", beep, 1);
    wait_idle("t1_idle");
    check("t1_n_short", n_short - s_short, 1);
    check("t1_n_long", n_long - s_long, 0);
    check("t1_busy_cycles", n_busy - s_busy, 20);
    check("t1_beep_hi", n_hi - s_hi, 8);
    check("t1_beep_rises", n_rise - s_rise, 2);

    // 2: 250-clock press -> long at hold 100, three bursts, silent release
    snap();
    key_in = 1'b0;
    step(100);
    check("t2_long_early", long_pulse, 0);
    step(1);
    check("t2_long_pulse", long_pulse, 1);
    check("t2_still_held", key_held, 1);
    step(149);
    key_in = 1'b1;
    step(5);
    wait_idle("t2_idle");
    check("t2_n_long", n_long - s_long, 1);
    check("t2_n_short", n_short - s_short, 0);
    check("t2_busy_cycles", n_busy - s_busy, 80);
    check("t2_beep_rises", n_rise - s_rise, 6);
    check("t2_beep_hi", n_hi - s_hi, 24);

    // 3: short press lands in the 2nd gap -> restart with a single burst
    snap();
    key_in = 1'b0;
    step(120);
    key_in = 1'b1;
    step(20);
    key_in = 1'b0;
    step(14);
    key_in = 1'b1;
    step(1);
    check("t3_short_pulse", short_pulse, 1);
    check("t3_busy", beep_busy, 1);
    wait_idle("t3_idle");
    check("t3_n_long", n_long - s_long, 1);
    check("t3_n_short", n_short - s_short, 1);
    check("t3_busy_cycles", n_busy - s_busy, 74);
    check("t3_beep_rises", n_rise - s_rise, 6);

    // 4: muted long press keeps timing but never drives beep
    mute = 1'b1;
    snap();
    key_in = 1'b0;
    step(101);
    check("t4_long_pulse", long_pulse, 1);
    step(99);
    key_in = 1'b1;
    step(1);
    wait_idle("t4_idle");
    check("t4_n_long", n_long - s_long, 1);
    check("t4_busy_cycles", n_busy - s_busy, 80);
    check("t4_beep_hi", n_hi - s_hi, 0);
    mute = 1'b0;

    // 5: reset mid-ON with the key held; held key is ignored until re-pressed
    snap();
    key_in = 1'b0;
    step(101);
    check("t5_long_pulse", long_pulse, 1);
    step(10);
    sys_rst_n = 1'b0;
    step(1);
    check("t5_rst_beep", beep, 0);
    check("t5_rst_busy", beep_busy, 0);
    check("t5_rst_short", short_pulse, 0);
    check("t5_rst_long", long_pulse, 0);
    check("t5_rst_held", key_held, 0);
    sys_rst_n = 1'b1;
    step(150);
    check("t5_no_relong", n_long - s_long, 1);
    check("t5_busy_cycles", n_busy - s_busy, 11);
    key_in = 1'b1;
    step(3);
    check("t5_silent_release", n_short - s_short, 0);
    key_in = 1'b0;
    step(10);
    key_in = 1'b1;
    step(1);
    check("t5_repress_short", short_pulse, 1);
    wait_idle("t5_idle");

    // 6a: release with hold_cnt = 99 -> short
    snap();
    key_in = 1'b0;
    step(100);
    key_in = 1'b1;
    step(1);
    check("t6a_short_pulse", short_pulse, 1);
    wait_idle("t6a_idle");
    check("t6a_n_long", n_long - s_long, 0);
    check("t6a_n_short", n_short - s_short, 1);

    // 6b: release with hold_cnt = 100 -> long only
    snap();
    key_in = 1'b0;
    step(101);
    check("t6b_long_pulse", long_pulse, 1);
    key_in = 1'b1;
    step(1);
    check("t6b_no_short", short_pulse, 0);
    wait_idle("t6b_idle");
    check("t6b_n_long", n_long - s_long, 1);
    check("t6b_n_short", n_short - s_short, 0);

    check("both_pulses_same_cycle", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
